// File: rtl/e1_pkg.sv
// Shared E1 TX PHY definitions: HDB3 symbol codes, period-adjust codes and
// the helper that turns an adjust code into a bit period in clock cycles.
package e1_pkg;

   localparam logic [1:0] SYM_SPACE = 2'b00;
   localparam logic [1:0] SYM_POS   = 2'b10;
   localparam logic [1:0] SYM_NEG   = 2'b01;
   localparam logic [1:0] SYM_ILL   = 2'b11;

   localparam logic [1:0] ADJ_NOM   = 2'b00;
   localparam logic [1:0] ADJ_INC   = 2'b01;
   localparam logic [1:0] ADJ_DEC   = 2'b10;

   // Code 11 is reserved and behaves as nominal.
   function automatic int bit_period(input logic [1:0] adj, input int bit_len);
      case (adj)
         ADJ_NOM: return bit_len;
         ADJ_INC: return bit_len + 1;
         ADJ_DEC: return bit_len - 1;
         default: return bit_len;
      endcase
   endfunction

endpackage

// File: rtl/e1_tx_phy_mc_if.sv
// Symbol handshake, period adjust and run-enable bundle for the E1 TX PHY.
interface e1_tx_phy_mc_if #(
   parameter int NCH = 1
);
   logic [NCH-1:0]   in_hi;
   logic [NCH-1:0]   in_lo;
   logic [NCH-1:0]   in_valid;
   logic [NCH-1:0]   in_ready;
   logic [2*NCH-1:0] tim_adj;
   logic [NCH-1:0]   enable;

   modport master (output in_hi, in_lo, in_valid, tim_adj, enable, input in_ready);
   modport slave  (input in_hi, in_lo, in_valid, tim_adj, enable, output in_ready);
endinterface

// File: rtl/e1_tx_phy_chan.sv
// One E1 TX channel: bit counter, held symbol, RZ pulse generator and pad
// registers. E1_TX_PHY_SB_IO_EN selects iCE40 SB_IO output registers for the pads.
module e1_tx_phy_chan
   import e1_pkg::*;
#(
   parameter int BIT_LEN   = 15,
   parameter int PULSE_LEN = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_enable,
   input  logic       i_hi,
   input  logic       i_lo,
   input  logic       i_valid,
   input  logic [1:0] i_adj,
   output logic       o_ready,
   output logic       o_stb,
   output logic       o_underrun,
   output logic       o_err_sym,
   output logic       o_pad_hi,
   output logic       o_pad_lo
);
   localparam int CW = $clog2(BIT_LEN + 2);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_plen;
   logic          r_run;
   logic [1:0]    r_sym;
   logic          r_underrun;
   logic          r_err_sym;

   logic [1:0]    w_sym_in;
   logic [CW-1:0] w_plen;
   logic          w_bnd;
   logic          w_in_pulse;
   logic          w_pad_hi_next;
   logic          w_pad_lo_next;

   assign w_sym_in = {i_hi, i_lo};
   assign w_plen   = CW'(bit_period(i_adj, BIT_LEN));
   // r_run delays the first boundary to the cycle after enable is seen high.
   assign w_bnd    = i_enable & r_run & (r_cnt == '0);
   assign w_in_pulse = (r_cnt != '0) && (r_cnt <= CW'(PULSE_LEN));

   assign w_pad_hi_next = ~rst & i_enable & w_in_pulse & (r_sym == SYM_POS);
   assign w_pad_lo_next = ~rst & i_enable & w_in_pulse & (r_sym == SYM_NEG);

   assign o_ready    = w_bnd;
   assign o_stb      = w_bnd;
   assign o_underrun = r_underrun;
   assign o_err_sym  = r_err_sym;

   always_ff @(posedge clk) begin
      if (rst || !i_enable) begin
         r_cnt      <= '0;
         r_plen     <= CW'(BIT_LEN);
         r_run      <= 1'b0;
         r_sym      <= SYM_SPACE;
         r_underrun <= 1'b0;
         r_err_sym  <= 1'b0;
      end else begin
         r_run      <= 1'b1;
         r_underrun <= w_bnd & ~i_valid;
         r_err_sym  <= w_bnd & i_valid & (w_sym_in == SYM_ILL);
         if (w_bnd) begin
            r_cnt  <= CW'(1);
            r_plen <= w_plen;
            r_sym  <= (i_valid && (w_sym_in != SYM_ILL)) ? w_sym_in : SYM_SPACE;
         end else if (r_run) begin
            r_cnt <= (r_cnt == r_plen - CW'(1)) ? '0 : r_cnt + CW'(1);
         end
      end
   end

`ifdef E1_TX_PHY_SB_IO_EN
   // Reset is folded into D, so these behave exactly like the fabric flops.
   SB_IO #(.PIN_TYPE(6'b010100)) u_pad_hi (
      .PACKAGE_PIN (o_pad_hi),
      .OUTPUT_CLK  (clk),
      .D_OUT_0     (w_pad_hi_next)
   );
   SB_IO #(.PIN_TYPE(6'b010100)) u_pad_lo (
      .PACKAGE_PIN (o_pad_lo),
      .OUTPUT_CLK  (clk),
      .D_OUT_0     (w_pad_lo_next)
   );
`else
   logic r_pad_hi;
   logic r_pad_lo;

   always_ff @(posedge clk) begin
      r_pad_hi <= w_pad_hi_next;
      r_pad_lo <= w_pad_lo_next;
   end

   assign o_pad_hi = r_pad_hi;
   assign o_pad_lo = r_pad_lo;
`endif

endmodule

// File: rtl/e1_tx_phy_mc.sv
// Multi-channel E1 TX PHY: NCH independent HDB3-symbol-to-RZ-pulse channels.
// Build option E1_TX_PHY_SB_IO_EN drives the pads from iCE40 SB_IO registers.
module e1_tx_phy_mc #(
   parameter int NCH       = 1,
   parameter int BIT_LEN   = 15,
   parameter int PULSE_LEN = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   e1_tx_phy_mc_if.slave        s_if,
   output logic [NCH-1:0]       pad_tx_hi,
   output logic [NCH-1:0]       pad_tx_lo,
   output logic [NCH-1:0]       stb_bit,
   output logic [NCH-1:0]       underrun,
   output logic [NCH-1:0]       err_sym
);

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
         e1_tx_phy_chan #(
            .BIT_LEN   (BIT_LEN),
            .PULSE_LEN (PULSE_LEN)
         ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_enable   (s_if.enable[gi]),
            .i_hi       (s_if.in_hi[gi]),
            .i_lo       (s_if.in_lo[gi]),
            .i_valid    (s_if.in_valid[gi]),
            .i_adj      (s_if.tim_adj[2*gi +: 2]),
            .o_ready    (s_if.in_ready[gi]),
            .o_stb      (stb_bit[gi]),
            .o_underrun (underrun[gi]),
            .o_err_sym  (err_sym[gi]),
            .o_pad_hi   (pad_tx_hi[gi]),
            .o_pad_lo   (pad_tx_lo[gi])
         );
      end
   endgenerate

endmodule
